// File: rtl/light_phase_sequencer_if.sv
// Signal bundle between the traffic-light sequencer and its surroundings.
// The slave modport is the sequencer side; master is the controller/sensor side.
interface light_phase_sequencer_if;
  logic       a_traffic;
  logic       b_traffic;
  logic       man_en;
  logic       man_a;
  logic       man_b;
  logic       a_light;
  logic       b_light;
  logic [3:0] a_time_l;
  logic [3:0] a_time_h;
  logic [3:0] b_time_l;
  logic [3:0] b_time_h;

  modport master (
    output a_traffic, b_traffic, man_en, man_a, man_b,
    input  a_light, b_light, a_time_l, a_time_h, b_time_l, b_time_h
  );

  modport slave (
    input  a_traffic, b_traffic, man_en, man_a, man_b,
    output a_light, b_light, a_time_l, a_time_h, b_time_l, b_time_h
  );
endinterface

// File: rtl/light_phase_sequencer.sv
// Two-road traffic light phase sequencer with BCD countdown display,
// traffic-extended greens and a police manual override.
// Optional feature: define LIGHT_WINK_EN to add the idle "wink" mode, where
// both lights blink together after CHECK_TIME ticks without any traffic.
module light_phase_sequencer #(
  parameter int TICK_DIV     = 50000000,
  parameter int GREEN_A_TIME = 30,
  parameter int GREEN_B_TIME = 20,
  parameter int ALLRED_TIME  = 3,
  parameter int CHECK_TIME   = 60
) (
  input logic                    clk,
  input logic                    rst_n,
  light_phase_sequencer_if.slave bus
);

  // Elaboration-time sanity check on the configuration.
  if (TICK_DIV < 2 || CHECK_TIME < 1 || CHECK_TIME > 255 ||
      GREEN_A_TIME < 1 || GREEN_A_TIME > 99 || GREEN_B_TIME < 1 ||
      GREEN_B_TIME > 99 || ALLRED_TIME < 1 || ALLRED_TIME > 99) begin : g_bad_param
    $error("light_phase_sequencer: parameter out of range");
  end

  localparam int PW = $clog2(TICK_DIV);

  // Durations pre-encoded as two BCD digits {high, low}.
  localparam logic [7:0] GREEN_A_BCD = 8'((GREEN_A_TIME / 10) * 16 + GREEN_A_TIME % 10);
  localparam logic [7:0] GREEN_B_BCD = 8'((GREEN_B_TIME / 10) * 16 + GREEN_B_TIME % 10);
  localparam logic [7:0] ALLRED_BCD  = 8'((ALLRED_TIME / 10) * 16 + ALLRED_TIME % 10);

  typedef enum logic [2:0] {
    A_GREEN,
    RED_AB,
    B_GREEN,
    RED_BA,
`ifdef LIGHT_WINK_EN
    WINK,
`endif
    MANUAL
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;      // countdown, BCD
  logic [7:0]    disp_q, disp_d;    // displayed digit pair, shared by A and B
  logic [PW-1:0] pre_q;
  logic          tick;
  logic          a_light, b_light;
  logic          any_traffic;

  assign tick        = (pre_q == PW'(TICK_DIV - 1));
  assign any_traffic = bus.a_traffic | bus.b_traffic;

  // BCD decrement; only ever applied to values >= 02.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Free-running one-second prescaler, independent of the phase state.
  // NOTE: async reset lives in the sensitivity list; state uses <= so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + PW'(1);
  end

`ifdef LIGHT_WINK_EN
  logic [7:0] idle_q;
  logic       wink_q, wink_d;
  logic       idle_hit;

  // Entering wink happens on the tick that brings the idle count to CHECK_TIME.
  assign idle_hit = !any_traffic && (idle_q >= 8'(CHECK_TIME - 1));

  // Saturating count of consecutive no-traffic ticks; cleared by traffic or override.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    idle_q <= '0;
    else if (state_q == MANUAL || any_traffic)     idle_q <= '0;
    else if (tick && idle_q < 8'(CHECK_TIME))      idle_q <= idle_q + 8'd1;
  end

  // Blink phase of the wink mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wink_q <= 1'b0;
    else        wink_q <= wink_d;
  end
`endif

  // Phase state, countdown and registered display digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RED_BA;
      cnt_q   <= ALLRED_BCD;
      disp_q  <= ALLRED_BCD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  // Next-state logic; priority is override, then wink entry, then countdown.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef LIGHT_WINK_EN
    wink_d  = wink_q;
`endif
    if (bus.man_en) begin
      state_d = MANUAL;
    end else if (state_q == MANUAL) begin
      state_d = RED_BA;
      cnt_d   = ALLRED_BCD;
`ifdef LIGHT_WINK_EN
    end else if (state_q == WINK) begin
      if (any_traffic) begin
        state_d = RED_BA;
        cnt_d   = ALLRED_BCD;
      end else if (tick) begin
        wink_d  = ~wink_q;
      end
    end else if (tick && idle_hit) begin
      state_d = WINK;
      wink_d  = 1'b1;
`endif
    end else if (tick) begin
      if (cnt_q == 8'h01) begin
        case (state_q)
          A_GREEN: begin
            if (bus.a_traffic && !bus.b_traffic) cnt_d = GREEN_A_BCD;
            else begin state_d = RED_AB; cnt_d = ALLRED_BCD; end
          end
          RED_AB:  begin state_d = B_GREEN; cnt_d = GREEN_B_BCD; end
          B_GREEN: begin
            if (bus.b_traffic && !bus.a_traffic) cnt_d = GREEN_B_BCD;
            else begin state_d = RED_BA; cnt_d = ALLRED_BCD; end
          end
          RED_BA:  begin state_d = A_GREEN; cnt_d = GREEN_A_BCD; end
          default: ;
        endcase
      end else begin
        cnt_d = bcd_dec(cnt_q);
      end
    end
  end

  // Display content follows the next state so digits never lag the phase.
  always_comb begin
    disp_d = cnt_d;
    case (state_d)
      MANUAL:  disp_d = 8'hFF;
`ifdef LIGHT_WINK_EN
      WINK:    disp_d = 8'hAA;
`endif
      default: ;
    endcase
  end

  // Light decode from the current phase.
  always_comb begin
    a_light = 1'b0;
    b_light = 1'b0;
    case (state_q)
      A_GREEN: a_light = 1'b1;
      B_GREEN: b_light = 1'b1;
      MANUAL:  begin a_light = bus.man_a; b_light = bus.man_b; end
`ifdef LIGHT_WINK_EN
      WINK:    begin a_light = wink_q; b_light = wink_q; end
`endif
      default: ;
    endcase
  end

  assign bus.a_light  = a_light;
  assign bus.b_light  = b_light;
  assign bus.a_time_h = disp_q[7:4];
  assign bus.a_time_l = disp_q[3:0];
  assign bus.b_time_h = disp_q[7:4];
  assign bus.b_time_l = disp_q[3:0];

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Directed bench for light_phase_sequencer with TICK_DIV=4, GREEN_A=5,
// GREEN_B=3, ALLRED=2, CHECK=6; a second instance with GREEN_A=11 covers the
// BCD borrow from 10 to 09. Wink checks are built when LIGHT_WINK_EN is defined.
module tb_light_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   e;          // rising edges since the last reset release

  always #5 clk = ~clk;

  light_phase_sequencer_if u_if ();
  light_phase_sequencer_if u_if2 ();

  light_phase_sequencer #(
    .TICK_DIV(4), .GREEN_A_TIME(5), .GREEN_B_TIME(3), .ALLRED_TIME(2), .CHECK_TIME(6)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave)
  );

  light_phase_sequencer #(
    .TICK_DIV(4), .GREEN_A_TIME(11), .GREEN_B_TIME(3), .ALLRED_TIME(2), .CHECK_TIME(6)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(u_if2.slave)
  );

  // {a_light, b_light, a_time_h, a_time_l, b_time_h, b_time_l}
  logic [17:0] obs1, obs2;
  assign obs1 = {u_if.a_light, u_if.b_light, u_if.a_time_h, u_if.a_time_l,
                 u_if.b_time_h, u_if.b_time_l};
  assign obs2 = {u_if2.a_light, u_if2.b_light, u_if2.a_time_h, u_if2.a_time_l,
                 u_if2.b_time_h, u_if2.b_time_l};

  function automatic logic [17:0] ev(input logic a, input logic b, input logic [7:0] d);
    ev = {a, b, d, d};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to rising edge k (counted from reset release) and settle 1 time unit.
  task automatic run_to(input int k);
    repeat (k - e) @(posedge clk);
    e = k;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    e           = 0;
    rst_n       = 1'b0;
    u_if.a_traffic = 1'b1; u_if.b_traffic = 1'b1;
    u_if.man_en = 1'b0; u_if.man_a = 1'b0; u_if.man_b = 1'b0;
    u_if2.a_traffic = 1'b1; u_if2.b_traffic = 1'b1;
    u_if2.man_en = 1'b0; u_if2.man_a = 1'b0; u_if2.man_b = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs1, ev(1'b0, 1'b0, 8'h02));
    check("reset_state_dut2", obs2, ev(1'b0, 1'b0, 8'h02));

    @(negedge clk); rst_n = 1'b1; e = 0;
    run_to(1);  check("red_ba_02", obs1, ev(1'b0, 1'b0, 8'h02));
    run_to(3);  check("red_ba_02_hold", obs1, ev(1'b0, 1'b0, 8'h02));
    run_to(4);  check("red_ba_01", obs1, ev(1'b0, 1'b0, 8'h01));
    run_to(8);  check("a_green_05", obs1, ev(1'b1, 1'b0, 8'h05));
                check("dut2_a_green_11", obs2, ev(1'b1, 1'b0, 8'h11));
    run_to(11); check("a_green_05_hold", obs1, ev(1'b1, 1'b0, 8'h05));
    run_to(12); check("a_green_04", obs1, ev(1'b1, 1'b0, 8'h04));
                check("dut2_a_green_10", obs2, ev(1'b1, 1'b0, 8'h10));
    run_to(16); check("dut2_bcd_borrow_09", obs2, ev(1'b1, 1'b0, 8'h09));
    run_to(24); check("a_green_01", obs1, ev(1'b1, 1'b0, 8'h01));
    run_to(28); check("red_ab_02", obs1, ev(1'b0, 1'b0, 8'h02));
    run_to(32); check("red_ab_01", obs1, ev(1'b0, 1'b0, 8'h01));
    run_to(36); check("b_green_03", obs1, ev(1'b0, 1'b1, 8'h03));

    // Manual override in the middle of B green.
    run_to(37);
    u_if.man_en = 1'b1; u_if.man_a = 1'b0; u_if.man_b = 1'b1;
    run_to(38); check("manual_entry", obs1, ev(1'b0, 1'b1, 8'hFF));
    u_if.man_a = 1'b1; u_if.man_b = 1'b0;
    #1;         check("manual_follow", obs1, ev(1'b1, 1'b0, 8'hFF));
    run_to(40);
    u_if.man_en = 1'b0;
    run_to(41); check("manual_exit_red_ba_02", obs1, ev(1'b0, 1'b0, 8'h02));
    run_to(44); check("manual_exit_red_ba_01", obs1, ev(1'b0, 1'b0, 8'h01));
    run_to(48); check("manual_exit_a_green_05", obs1, ev(1'b1, 1'b0, 8'h05));

    // A-only traffic at the last A green second extends the green.
    run_to(64); check("a_green_01_again", obs1, ev(1'b1, 1'b0, 8'h01));
    u_if.b_traffic = 1'b0;
    run_to(67); check("a_green_01_hold", obs1, ev(1'b1, 1'b0, 8'h01));
    run_to(68); check("a_green_extend_05", obs1, ev(1'b1, 1'b0, 8'h05));
    u_if.b_traffic = 1'b1;
    run_to(84); check("a_green_ext_01", obs1, ev(1'b1, 1'b0, 8'h01));
    run_to(88); check("a_green_ext_red_ab", obs1, ev(1'b0, 1'b0, 8'h02));
    run_to(116); check("cycle_a_green_05", obs1, ev(1'b1, 1'b0, 8'h05));

    // Asynchronous reset in the middle of A green.
    run_to(118);
    rst_n = 1'b0;
    #1;         check("async_reset_mid_green", obs1, ev(1'b0, 1'b0, 8'h02));
    u_if.a_traffic = 1'b0; u_if.b_traffic = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; e = 0;
    run_to(3);  check("post_reset_02_hold", obs1, ev(1'b0, 1'b0, 8'h02));
    run_to(4);  check("post_reset_first_tick", obs1, ev(1'b0, 1'b0, 8'h01));
    run_to(8);  check("idle_a_green_05", obs1, ev(1'b1, 1'b0, 8'h05));
`ifdef LIGHT_WINK_EN
    run_to(23); check("idle_a_green_02", obs1, ev(1'b1, 1'b0, 8'h02));
    run_to(24); check("wink_entry_on", obs1, ev(1'b1, 1'b1, 8'hAA));
    run_to(27); check("wink_on_hold", obs1, ev(1'b1, 1'b1, 8'hAA));
    run_to(28); check("wink_off", obs1, ev(1'b0, 1'b0, 8'hAA));
    run_to(32); check("wink_on_again", obs1, ev(1'b1, 1'b1, 8'hAA));
    run_to(33);
    u_if.b_traffic = 1'b1;
    run_to(34); check("wink_exit_red_ba_02", obs1, ev(1'b0, 1'b0, 8'h02));
`else
    run_to(24); check("idle_a_green_01", obs1, ev(1'b1, 1'b0, 8'h01));
    run_to(28); check("idle_red_ab_02", obs1, ev(1'b0, 1'b0, 8'h02));
    run_to(36); check("idle_b_green_03", obs1, ev(1'b0, 1'b1, 8'h03));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
